// File: rtl/item_pkg.sv
// item_pkg: shared encodings and widths for the item bank.
//   item_state_e : per-item state encoding (HIDDEN=0, RISING=1, ACTIVE=2, COLLECTED=3)
//   COORD_W      : width of every screen/world coordinate
//   OVL_W        : width used by the hit test so that sums never wrap
package item_pkg;

   typedef enum logic [1:0] {
      ST_HIDDEN    = 2'd0,
      ST_RISING    = 2'd1,
      ST_ACTIVE    = 2'd2,
      ST_COLLECTED = 2'd3
   } item_state_e;

   localparam int COORD_W = 10;
   localparam int OVL_W   = 11;

endpackage

// File: rtl/item_slot.sv
// item_slot: one pickup item -- state machine, rise timer, optional respawn
// timer and character/item hit test.
// Ports:
//   sys_clk, RST        clock, synchronous active-high reset
//   tick                frame strobe advancing rise/respawn timing
//   char_X, char_Y      character world position (top-left)
//   bg_pos              background scroll offset
//   reveal              block-hit request (honoured only in HIDDEN)
//   item_x, item_y      registered screen X / current Y
//   item_vis            draw enable
//   hit                 ACTIVE and overlapping this cycle (collected at next edge)
// Optional feature: macro ITEM_BANK_RESPAWN_EN adds a respawn countdown in
// COLLECTED; without it COLLECTED holds until RST.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// HIDDEN    | inside the block, invisible, waiting for reveal
// RISING    | emerging: Y steps up from Y_INIT+ITEM_W to Y_INIT over RISE_STEPS ticks
// ACTIVE    | resting at Y_INIT, visible, can be collected
// COLLECTED | taken; invisible (respawn countdown when enabled)
module item_slot
   import item_pkg::*;
#(
   parameter logic [COORD_W-1:0] X_INIT        = 10'd260,
   parameter logic [COORD_W-1:0] Y_INIT        = 10'd115,
   parameter bit                 START_ACT     = 1'b1,
   parameter int                 ITEM_W        = 12,
   parameter int                 CHAR_W        = 12,
   parameter int                 RISE_STEPS    = 12
`ifdef ITEM_BANK_RESPAWN_EN
   ,
   parameter int                 RESPAWN_TICKS = 600
`endif
) (
   input  logic               sys_clk,
   input  logic               RST,
   input  logic               tick,
   input  logic [COORD_W-1:0] char_X,
   input  logic [COORD_W-1:0] char_Y,
   input  logic [COORD_W-1:0] bg_pos,
   input  logic               reveal,
   output logic [COORD_W-1:0] item_x,
   output logic [COORD_W-1:0] item_y,
   output logic               item_vis,
   output logic               hit
);

   localparam int STEP_RAW = ITEM_W / RISE_STEPS;
   localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;
   localparam int RISE_CW  = $clog2(RISE_STEPS + 1);
   localparam logic [COORD_W-1:0] Y_LOW     = COORD_W'(Y_INIT + ITEM_W);
   localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
   localparam logic [RISE_CW-1:0] RISE_LOAD = RISE_CW'(RISE_STEPS);
   localparam item_state_e        ST_RESET  = START_ACT ? ST_ACTIVE : ST_HIDDEN;

   item_state_e          state_q, state_d;
   logic [COORD_W-1:0]   item_x_q, item_x_d;
   logic [COORD_W-1:0]   item_y_q, item_y_d;
   logic [RISE_CW-1:0]   rise_cnt_q, rise_cnt_d;
`ifdef ITEM_BANK_RESPAWN_EN
   localparam logic [COORD_W-1:0] RESP_LOAD = COORD_W'(RESPAWN_TICKS);
   logic [COORD_W-1:0]   resp_cnt_q, resp_cnt_d;
`endif

   // Hit test in OVL_W bits: X uses the world position, Y the current item Y.
   logic [OVL_W-1:0] cx, cy, ix, iy;
   logic             overlap;

   assign cx = {1'b0, char_X};
   assign cy = {1'b0, char_Y};
   assign ix = {1'b0, X_INIT};
   assign iy = {1'b0, item_y_q};

   assign overlap = (cx + OVL_W'(CHAR_W) > ix) && (ix + OVL_W'(ITEM_W) > cx) &&
                    (cy + OVL_W'(CHAR_W) > iy) && (iy + OVL_W'(ITEM_W) > cy);

   assign hit      = (state_q == ST_ACTIVE) && overlap;
   assign item_vis = (state_q == ST_RISING) || (state_q == ST_ACTIVE);
   assign item_x   = item_x_q;
   assign item_y   = item_y_q;

   always_comb begin
      state_d    = state_q;
      item_x_d   = X_INIT - bg_pos;
      item_y_d   = item_y_q;
      rise_cnt_d = rise_cnt_q;
`ifdef ITEM_BANK_RESPAWN_EN
      resp_cnt_d = resp_cnt_q;
`endif
      case (state_q)
         ST_HIDDEN: begin
            if (reveal) begin
               state_d    = ST_RISING;
               item_y_d   = Y_LOW;
               rise_cnt_d = RISE_LOAD;
            end
         end
         ST_RISING: begin
            if (tick) begin
               // Last tick snaps to Y_INIT so truncated steps never leave an offset.
               if (rise_cnt_q <= RISE_CW'(1)) begin
                  state_d    = ST_ACTIVE;
                  item_y_d   = Y_INIT;
                  rise_cnt_d = '0;
               end else begin
                  rise_cnt_d = rise_cnt_q - RISE_CW'(1);
                  item_y_d   = item_y_q - STEP_C;
               end
            end
         end
         ST_ACTIVE: begin
            if (overlap) begin
               state_d = ST_COLLECTED;
`ifdef ITEM_BANK_RESPAWN_EN
               resp_cnt_d = RESP_LOAD;
`endif
            end
         end
         ST_COLLECTED: begin
`ifdef ITEM_BANK_RESPAWN_EN
            if (tick) begin
               if (resp_cnt_q <= COORD_W'(1)) begin
                  state_d    = ST_HIDDEN;
                  item_y_d   = Y_INIT;
                  resp_cnt_d = '0;
               end else begin
                  resp_cnt_d = resp_cnt_q - COORD_W'(1);
               end
            end
`endif
         end
         default: state_d = ST_HIDDEN;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (RST) begin
         state_q    <= ST_RESET;
         item_x_q   <= X_INIT;
         item_y_q   <= Y_INIT;
         rise_cnt_q <= '0;
`ifdef ITEM_BANK_RESPAWN_EN
         resp_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         item_x_q   <= item_x_d;
         item_y_q   <= item_y_d;
         rise_cnt_q <= rise_cnt_d;
`ifdef ITEM_BANK_RESPAWN_EN
         resp_cnt_q <= resp_cnt_d;
`endif
      end
   end

endmodule

// File: rtl/item_bank.sv
// item_bank: N_ITEMS independent pickup items plus collection reporting.
// Ports:
//   sys_clk, RST        clock, synchronous active-high reset
//   tick                frame strobe
//   char_X, char_Y      character world position
//   bg_pos              background scroll offset
//   reveal[N]           per-item block-hit request
//   item_x/item_y       packed 10-bit screen X / current Y per item
//   item_vis[N]         per-item draw enable
//   touch               one-cycle pulse when any item is collected
//   touch_id            lowest collected index in the pulse cycle
//   touch_mask          every item collected in the pulse cycle
//   collected_cnt       saturating collection count
// Optional feature: macro ITEM_BANK_RESPAWN_EN enables respawn after
// RESPAWN_TICKS frame ticks in COLLECTED.
module item_bank
   import item_pkg::*;
#(
   parameter int                           N_ITEMS       = 4,
   parameter logic [COORD_W*N_ITEMS-1:0]   ITEM_X_INIT   = {N_ITEMS{10'd260}},
   parameter logic [COORD_W*N_ITEMS-1:0]   ITEM_Y_INIT   = {N_ITEMS{10'd115}},
   parameter logic [N_ITEMS-1:0]           START_ACTIVE  = '1,
   parameter int                           ITEM_W        = 12,
   parameter int                           CHAR_W        = 12,
   parameter int                           RISE_STEPS    = 12,
   parameter int                           RESPAWN_TICKS = 600
) (
   input  logic                         sys_clk,
   input  logic                         RST,
   input  logic                         tick,
   input  logic [COORD_W-1:0]           char_X,
   input  logic [COORD_W-1:0]           char_Y,
   input  logic [COORD_W-1:0]           bg_pos,
   input  logic [N_ITEMS-1:0]           reveal,
   output logic [COORD_W*N_ITEMS-1:0]   item_x,
   output logic [COORD_W*N_ITEMS-1:0]   item_y,
   output logic [N_ITEMS-1:0]           item_vis,
   output logic                         touch,
   output logic [3:0]                   touch_id,
   output logic [N_ITEMS-1:0]           touch_mask,
   output logic [7:0]                   collected_cnt
);

   logic [N_ITEMS-1:0] hit;

   for (genvar g = 0; g < N_ITEMS; g++) begin : g_slot
      item_slot #(
         .X_INIT     (ITEM_X_INIT[COORD_W*g +: COORD_W]),
         .Y_INIT     (ITEM_Y_INIT[COORD_W*g +: COORD_W]),
         .START_ACT  (START_ACTIVE[g]),
         .ITEM_W     (ITEM_W),
         .CHAR_W     (CHAR_W),
         .RISE_STEPS (RISE_STEPS)
`ifdef ITEM_BANK_RESPAWN_EN
         ,
         .RESPAWN_TICKS (RESPAWN_TICKS)
`endif
      ) u_slot (
         .sys_clk  (sys_clk),
         .RST      (RST),
         .tick     (tick),
         .char_X   (char_X),
         .char_Y   (char_Y),
         .bg_pos   (bg_pos),
         .reveal   (reveal[g]),
         .item_x   (item_x[COORD_W*g +: COORD_W]),
         .item_y   (item_y[COORD_W*g +: COORD_W]),
         .item_vis (item_vis[g]),
         .hit      (hit[g])
      );
   end

   logic               touch_q, touch_d;
   logic [3:0]         touch_id_q, touch_id_d;
   logic [N_ITEMS-1:0] touch_mask_q, touch_mask_d;
   logic [7:0]         collected_cnt_q, collected_cnt_d;
   logic [4:0]         pop;
   logic [8:0]         cnt_sum;

   always_comb begin
      touch_d      = |hit;
      touch_mask_d = hit;
      touch_id_d   = '0;
      pop          = '0;
      // Scan downward so the lowest set index is written last.
      for (int i = N_ITEMS - 1; i >= 0; i--) begin
         if (hit[i]) touch_id_d = 4'(i);
      end
      for (int i = 0; i < N_ITEMS; i++) begin
         pop = pop + 5'(hit[i]);
      end
      cnt_sum         = {1'b0, collected_cnt_q} + {4'd0, pop};
      collected_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
   end

   always_ff @(posedge sys_clk) begin
      if (RST) begin
         touch_q         <= 1'b0;
         touch_id_q      <= '0;
         touch_mask_q    <= '0;
         collected_cnt_q <= '0;
      end else begin
         touch_q         <= touch_d;
         touch_id_q      <= touch_id_d;
         touch_mask_q    <= touch_mask_d;
         collected_cnt_q <= collected_cnt_d;
      end
   end

   assign touch         = touch_q;
   assign touch_id      = touch_id_q;
   assign touch_mask    = touch_mask_q;
   assign collected_cnt = collected_cnt_q;

endmodule

// File: tb/tb_item_bank.sv
// tb_item_bank: two item_bank instances. dut1 uses all defaults (all items
// active); dut2 starts with items 1 and 3 active, 0 and 2 hidden, and a
// respawn period of 3 ticks. Expected touch events are queued when the
// stimulus is applied and checked by a negedge monitor.
module tb_item_bank;

   typedef struct {
      logic [3:0] id;
      logic [3:0] mask;
      logic [7:0] cnt;
      int         due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst1, rst2, tick1, tick2;
   logic [9:0]  c1x, c1y, c2x, c2y, bg1, bg2;
   logic [3:0]  rev1, rev2;
   logic [39:0] ix1, iy1, ix2, iy2;
   logic [3:0]  vis1, vis2, tmask1, tmask2;
   logic        touch1, touch2;
   logic [3:0]  tid1, tid2;
   logic [7:0]  cnt1, cnt2;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t q1[$];
   exp_t q2[$];
   int   m1 = 0;
   int   m2 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   item_bank dut1 (
      .sys_clk(clk), .RST(rst1), .tick(tick1), .char_X(c1x), .char_Y(c1y),
      .bg_pos(bg1), .reveal(rev1), .item_x(ix1), .item_y(iy1), .item_vis(vis1),
      .touch(touch1), .touch_id(tid1), .touch_mask(tmask1), .collected_cnt(cnt1)
   );

   item_bank #(.START_ACTIVE(4'b1010), .RESPAWN_TICKS(3)) dut2 (
      .sys_clk(clk), .RST(rst2), .tick(tick2), .char_X(c2x), .char_Y(c2y),
      .bg_pos(bg2), .reveal(rev2), .item_x(ix2), .item_y(iy2), .item_vis(vis2),
      .touch(touch2), .touch_id(tid2), .touch_mask(tmask2), .collected_cnt(cnt2)
   );

   function automatic logic [9:0] f10(input logic [39:0] bus, input int i);
      return bus[10*i +: 10];
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_2();
      tick2 = 1'b1;
      step();
      tick2 = 1'b0;
      step();
   endtask

   task automatic push(input int d, input logic [3:0] id, input logic [3:0] mk, input int cnt);
      exp_t e;
      e.id = id;
      e.mask = mk;
      e.cnt = 8'(cnt);
      e.due = cyc + 1;
      if (d == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   task automatic mon_one(input int d, input logic t, input logic [3:0] id,
                          input logic [3:0] mk, input logic [7:0] cnt);
      exp_t e;
      int   n;
      n = (d == 1) ? q1.size() : q2.size();
      if (!t) begin
         chk($sformatf("idle_id_mask_dut%0d", d), int'({id, mk}), 0);
      end else if (n == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_touch_dut%0d act=touch id=%0d mask=%b exp=no_touch cyc=%0d",
                  d, id, mk, cyc);
      end else begin
         if (d == 1) e = q1.pop_front();
         else e = q2.pop_front();
         chk($sformatf("touch_id_dut%0d", d), int'(id), int'(e.id));
         chk($sformatf("touch_mask_dut%0d", d), int'(mk), int'(e.mask));
         chk($sformatf("collected_cnt_dut%0d", d), int'(cnt), int'(e.cnt));
         chk($sformatf("touch_cycle_dut%0d", d), cyc, e.due);
      end
   endtask

   always @(negedge clk) begin
      mon_one(1, touch1, tid1, tmask1, cnt1);
      mon_one(2, touch2, tid2, tmask2, cnt2);
   end

   initial begin
      rst1 = 1'b1; rst2 = 1'b1; tick1 = 1'b0; tick2 = 1'b0;
      c1x = '0; c1y = '0; c2x = '0; c2y = '0;
      bg1 = '0; bg2 = '0; rev1 = '0; rev2 = '0;
      step();
      step();
      rst1 = 1'b0; rst2 = 1'b0;

      // reset state
      for (int i = 0; i < 4; i++) begin
         chk("rst_item_x", int'(f10(ix1, i)), 260);
         chk("rst_item_y", int'(f10(iy1, i)), 115);
      end
      chk("rst_vis_dut1", int'(vis1), 4'b1111);
      chk("rst_vis_dut2", int'(vis2), 4'b1010);
      chk("rst_touch", int'({touch1, touch2}), 0);
      chk("rst_cnt_dut1", int'(cnt1), 0);
      chk("rst_cnt_dut2", int'(cnt2), 0);

      // single pickup: all four share a position
      c1x = 10'd255; c1y = 10'd110;
      m1 = 4;
      push(1, 4'd0, 4'b1111, m1);
      step();
      c1x = '0; c1y = '0;
      step();
      chk("t1_vis_after", int'(vis1), 0);
      chk("t1_cnt", int'(cnt1), 4);

      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      m1 = 0;
      chk("t1_rst_vis", int'(vis1), 4'b1111);
      chk("t1_rst_cnt", int'(cnt1), 0);

      // boundaries: edge-touching on each side must not collect
      c1x = 10'd248; c1y = 10'd110; step(); step();
      c1x = 10'd272; step(); step();
      c1x = 10'd255; c1y = 10'd103; step(); step();
      c1y = 10'd127; step(); step();
      chk("t2_vis_no_touch", int'(vis1), 4'b1111);
      c1x = 10'd249; c1y = 10'd110;
      m1 = 4;
      push(1, 4'd0, 4'b1111, m1);
      step();
      c1x = '0; c1y = '0;
      step();

      // scroll on dut1
      bg1 = 10'd5;
      step();
      chk("scroll_dut1_x0", int'(f10(ix1, 0)), 255);

      // priority: items 1 and 3 overlap together
      c2x = 10'd255; c2y = 10'd110;
      m2 = 2;
      push(2, 4'd1, 4'b1010, m2);
      step();
      c2x = '0; c2y = '0;
      step();
      chk("t4_vis_after", int'(vis2), 0);

      // reveal and rise of item 2; overlap while rising is ignored
      rev2 = 4'b0100;
      step();
      rev2 = '0;
      chk("t3_y_enter", int'(f10(iy2, 2)), 127);
      chk("t3_vis_enter", int'(vis2[2]), 1);
      c2x = 10'd255; c2y = 10'd110;
      for (int t = 1; t <= 11; t++) begin
         tick_2();
         chk($sformatf("t3_y_tick%0d", t), int'(f10(iy2, 2)), 127 - t);
         chk($sformatf("t3_vis_tick%0d", t), int'(vis2[2]), 1);
      end
      c2x = '0; c2y = '0;
      tick_2();
      chk("t3_y_final", int'(f10(iy2, 2)), 115);
      chk("t3_vis_final", int'(vis2[2]), 1);
      c2x = 10'd255; c2y = 10'd110;
      m2 = 3;
      push(2, 4'd2, 4'b0100, m2);
      step();
      c2x = '0; c2y = '0;
      step();
      chk("t3_vis_collected", int'(vis2[2]), 0);

      // reset in the middle of a rise, then scroll
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      m2 = 0;
      rev2 = 4'b0100;
      step();
      rev2 = '0;
      repeat (5) tick_2();
      chk("t5_y_tick5", int'(f10(iy2, 2)), 122);
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      chk("t5_vis_rst", int'(vis2), 4'b1010);
      chk("t5_y_rst", int'(f10(iy2, 2)), 115);
      chk("t5_cnt_rst", int'(cnt2), 0);
      bg2 = 10'd300;
      step();
      for (int i = 0; i < 4; i++) chk($sformatf("t5_item_x%0d", i), int'(f10(ix2, i)), 984);
      bg2 = '0;

      // respawn behaviour
      c2x = 10'd255; c2y = 10'd110;
      m2 = 2;
      push(2, 4'd1, 4'b1010, m2);
      step();
      c2x = '0; c2y = '0;
      step();
`ifdef ITEM_BANK_RESPAWN_EN
      tick_2();
      tick_2();
      rev2 = 4'b0010;
      step();
      rev2 = '0;
      chk("t6_reveal_ignored", int'(vis2), 0);
      tick_2();
      chk("t6_hidden_vis", int'(vis2), 0);
      rev2 = 4'b0010;
      step();
      rev2 = '0;
      chk("t6_respawn_vis", int'(vis2), 4'b0010);
      chk("t6_respawn_y", int'(f10(iy2, 1)), 127);
`else
      repeat (1000) tick_2();
      rev2 = 4'b1010;
      step();
      rev2 = '0;
      chk("t6_terminal_vis", int'(vis2), 0);
      chk("t6_terminal_cnt", int'(cnt2), 2);
`endif

      repeat (3) step();
      chk("pending_touch_dut1", q1.size(), 0);
      chk("pending_touch_dut2", q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/item_bank.md
ITEM_BANK -- requirements
Module: item_bank

Interface
REQ-001 Parameter N_ITEMS, default 4: number of independent pickup items, range 1..16.
REQ-002 Parameter ITEM_X_INIT, default {4{10'd260}}: packed N_ITEMS x 10-bit world X per item; item i occupies bits [10i+9:10i].
REQ-003 Parameter ITEM_Y_INIT, default {4{10'd115}}: packed N_ITEMS x 10-bit resting Y per item.
REQ-004 Parameter START_ACTIVE, default all-ones: N_ITEMS-bit mask; a set bit places the item in ACTIVE after reset, a clear bit places it in HIDDEN.
REQ-005 Parameter ITEM_W, default 12: item hitbox width and height in pixels.
REQ-006 Parameter CHAR_W, default 12: character hitbox width and height in pixels.
REQ-007 Parameter RISE_STEPS, default 12: frame ticks an item spends in RISING.
REQ-008 Parameter RESPAWN_TICKS, default 600: frame ticks before respawn; used only under REQ-033.
REQ-009 sys_clk  in  1  system clock; one clock domain.
REQ-010 RST  in  1  synchronous active-high reset.
REQ-011 tick  in  1  one-cycle frame strobe that advances rise and respawn timing.
REQ-012 char_X, char_Y  in  10 each  character world position, top-left corner.
REQ-013 bg_pos  in  10  background scroll offset.
REQ-014 reveal  in  N_ITEMS  per-item block-hit request.
REQ-015 item_x  out  10*N_ITEMS  screen X per item: world X minus bg_pos, modulo 1024.
REQ-016 item_y  out  10*N_ITEMS  current Y per item.
REQ-017 item_vis  out  N_ITEMS  per-item draw enable.
REQ-018 touch  out  1  one-cycle pulse when one or more items are collected.
REQ-019 touch_id  out  4  index of the collected item.
REQ-020 touch_mask  out  N_ITEMS  all items collected in the pulse cycle.
REQ-021 collected_cnt  out  8  saturating count of collections.

Function
REQ-022 Each item runs its own FSM with states HIDDEN, RISING, ACTIVE and COLLECTED.
REQ-023 HIDDEN->RISING when reveal[i]=1; reveal[i] is ignored in every other state.
REQ-024 On entering RISING, item_y = Y_INIT + ITEM_W.
- Each tick in RISING decrements item_y by ITEM_W/RISE_STEPS, integer division, minimum step 1.
- After RISE_STEPS ticks, item_y = Y_INIT exactly and the item goes to ACTIVE.
REQ-025 Hit test is done in 11-bit unsigned arithmetic so that it cannot wrap.
- Overlap iff char_X+CHAR_W > X_i and X_i+ITEM_W > char_X and char_Y+CHAR_W > Y_i and Y_i+ITEM_W > char_Y.
- Edge-touching boxes do not overlap.
REQ-026 Only ACTIVE items are tested; overlap sampled at edge k moves the item to COLLECTED and sets touch=1 for the cycle after edge k (latency 1).
REQ-027 If several items overlap in the same cycle, all of them are collected.
- touch pulses once.
- touch_id is the lowest such index.
- touch_mask has every such bit set.
- collected_cnt increases by the popcount of touch_mask, saturating at 255.
REQ-028 Outputs when touch=0: touch_id=0 and touch_mask=0.
REQ-029 item_vis[i]=1 in RISING and ACTIVE, and 0 in HIDDEN and COLLECTED.
REQ-030 item_x and item_y are registered and follow bg_pos with 1-cycle latency in every state.
REQ-031 A character that stays overlapping generates no further touch after the item leaves ACTIVE.

Reset
REQ-032 On RST at a clock edge:
- Each item returns to ACTIVE or HIDDEN per START_ACTIVE; this aborts RISING and any respawn countdown.
- item_y is set to Y_INIT.
- touch=0, touch_id=0, touch_mask=0, collected_cnt=0.
- item_vis equals START_ACTIVE.
- item_x is set to X_INIT minus 0 (bg_pos is treated as 0 for the reset value).

Configuration
REQ-033 Macro ITEM_BANK_RESPAWN_EN.
- Defined: COLLECTED loads a per-item 10-bit counter with RESPAWN_TICKS, decrements it on each tick, and goes to HIDDEN when it reaches 0.
- Not defined: COLLECTED is terminal until RST, and no counter logic is synthesised.

Structure
REQ-034 Package item_pkg holds:
- the state encoding (HIDDEN=0, RISING=1, ACTIVE=2, COLLECTED=3);
- the coordinate width constant 10;
- the overlap width constant 11.
REQ-035 Sub-module item_slot holds one item's FSM, rise counter, respawn counter and hit test, and is instantiated N_ITEMS times; item_bank holds the priority encoder, mask and count.

Verification
REQ-036 Test 1, single pickup:
- Stimulus: N=4 default; char at (255,110).
- Required: item 0 collected; touch pulses 1 cycle later with touch_id=0, touch_mask=4'b1111 (all items share the default position); collected_cnt=4.
REQ-037 Test 2, boundary:
- With item at X=260, char_X=248 (edge-touching) -> no touch.
- With char_X=249 -> touch.
REQ-038 Test 3, reveal and rise:
- Stimulus: START_ACTIVE=0; reveal[2] pulsed; 12 ticks.
- Required: item_y goes 127, then 126 down to 115 on successive ticks; item_vis[2]=1 from the cycle after reveal; state ACTIVE after the 12th tick.
- An overlap during RISING gives no touch.
REQ-039 Test 4, priority: items 1 and 3 overlap in the same cycle -> touch_id=1, touch_mask=4'b1010, collected_cnt +2.
REQ-040 Test 5, mid-operation reset and scroll:
- RST asserted at rise tick 5 -> item HIDDEN, item_y=115.
- bg_pos=300 with X=260 -> item_x=984.
REQ-041 Test 6, respawn:
- With ITEM_BANK_RESPAWN_EN and RESPAWN_TICKS=3: a collected item is HIDDEN after the 3rd tick and reveal works again.
- Without the macro: the item stays COLLECTED after 1000 ticks.
